// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding and the instruction opcodes.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SH_DR,
    ST_EX1_DR,
    ST_PAUSE_DR,
    ST_EX2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SH_IR,
    ST_EX1_IR,
    ST_PAUSE_IR,
    ST_EX2_IR,
    ST_UPD_IR
  } tap_state_t;

  localparam logic [4:0] OPC_IDCODE = 5'h01;
  localparam logic [4:0] OPC_USER   = 5'h02;
  localparam logic [4:0] OPC_BYPASS = 5'h1F;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: 16 states advanced by TMS on rising TCK.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       RESET,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t state_next;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) state <= ST_TLR;
    else       state <= state_next;
  end

  // NOTE: default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_TLR:      state_next = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_next = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_next = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_next = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_next = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_next = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_next = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_next = TMS ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_next = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_next = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_next = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_next = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_next = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_next = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_next = TMS ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_next = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_next = ST_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: state strobes, instruction register, select decode,
// internal IDCODE register and the falling-edge TDO output stage.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'h0000_53A1
) (
  input  logic                TCK,
  input  logic                RESET,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BYPASS_TDO,
  input  logic                USER_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                CAPTURE_IR,
  output logic                SHIFT_IR,
  output logic                UPDATE_IR,
  output logic                TEST_LOGIC_RESET,
  output logic                RUN_TEST_IDLE,
  output logic [IR_WIDTH-1:0] INSTRUCTION,
  output logic                SEL_BYPASS,
  output logic                SEL_IDCODE,
  output logic                SEL_USER
);

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(OPC_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(2'b01);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_reg;
  logic                dr_tdo;

  jtag_tap_fsm u_fsm (
    .TCK   (TCK),
    .RESET (RESET),
    .TMS   (TMS),
    .state (state)
  );

  // Moore strobes: downstream logic acts on the edge that leaves the state.
  assign TEST_LOGIC_RESET = (state == ST_TLR);
  assign RUN_TEST_IDLE    = (state == ST_RTI);
  assign CAPTURE_DR       = (state == ST_CAP_DR);
  assign SHIFT_DR         = (state == ST_SH_DR);
  assign UPDATE_DR        = (state == ST_UPD_DR);
  assign CAPTURE_IR       = (state == ST_CAP_IR);
  assign SHIFT_IR         = (state == ST_SH_IR);
  assign UPDATE_IR        = (state == ST_UPD_IR);

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET)           ir_shift <= '0;
    else if (CAPTURE_IR) ir_shift <= IR_CAPTURE;
    else if (SHIFT_IR)   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET)                 INSTRUCTION <= INSTR_IDCODE;
    else if (TEST_LOGIC_RESET) INSTRUCTION <= INSTR_IDCODE;
    else if (UPDATE_IR)        INSTRUCTION <= ir_shift;
  end

  // Unlisted opcodes fall through to bypass so exactly one select is ever high.
  always_comb begin
    SEL_IDCODE = 1'b0;
    SEL_USER   = 1'b0;
    SEL_BYPASS = 1'b0;
    if (INSTRUCTION == INSTR_IDCODE)    SEL_IDCODE = 1'b1;
    else if (INSTRUCTION == INSTR_USER) SEL_USER   = 1'b1;
    else                                SEL_BYPASS = 1'b1;
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET)                          idcode_reg <= IDCODE_VALUE;
    else if (CAPTURE_DR && SEL_IDCODE)  idcode_reg <= IDCODE_VALUE;
    else if (SHIFT_DR && SEL_IDCODE)    idcode_reg <= {TDI, idcode_reg[31:1]};
  end

  always_comb begin
    dr_tdo = BYPASS_TDO;
    if (SEL_IDCODE)    dr_tdo = idcode_reg[0];
    else if (SEL_USER) dr_tdo = USER_TDO;
  end

  // Falling-edge launch gives the external receiver half a cycle of setup.
  always_ff @(negedge TCK or posedge RESET) begin
    if (RESET) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= SHIFT_IR | SHIFT_DR;
      if (SHIFT_IR)      TDO <= ir_shift[0];
      else if (SHIFT_DR) TDO <= dr_tdo;
      else               TDO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: TDO bits are scoreboarded in a queue.
module tb_jtag_tap_controller;

  logic       TCK = 1'b0;
  logic       RESET, TMS, TDI, BYPASS_TDO, USER_TDO;
  logic       TDO, TDO_EN;
  logic       CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_IR, SHIFT_IR, UPDATE_IR;
  logic       TEST_LOGIC_RESET, RUN_TEST_IDLE;
  logic [4:0] INSTRUCTION;
  logic       SEL_BYPASS, SEL_IDCODE, SEL_USER;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic byp;

  localparam logic [31:0] IDCODE = 32'h0000_53A1;

  jtag_tap_controller dut (
    .TCK              (TCK),
    .RESET            (RESET),
    .TMS              (TMS),
    .TDI              (TDI),
    .BYPASS_TDO       (BYPASS_TDO),
    .USER_TDO         (USER_TDO),
    .TDO              (TDO),
    .TDO_EN           (TDO_EN),
    .CAPTURE_DR       (CAPTURE_DR),
    .SHIFT_DR         (SHIFT_DR),
    .UPDATE_DR        (UPDATE_DR),
    .CAPTURE_IR       (CAPTURE_IR),
    .SHIFT_IR         (SHIFT_IR),
    .UPDATE_IR        (UPDATE_IR),
    .TEST_LOGIC_RESET (TEST_LOGIC_RESET),
    .RUN_TEST_IDLE    (RUN_TEST_IDLE),
    .INSTRUCTION      (INSTRUCTION),
    .SEL_BYPASS       (SEL_BYPASS),
    .SEL_IDCODE       (SEL_IDCODE),
    .SEL_USER         (SEL_USER)
  );

  always #5 TCK = ~TCK;

  // External one-bit bypass register driven by the DUT strobes.
  always @(posedge TCK or posedge RESET) begin
    if (RESET)                          byp <= 1'b0;
    else if (CAPTURE_DR && SEL_BYPASS)  byp <= 1'b0;
    else if (SHIFT_DR && SEL_BYPASS)    byp <= TDI;
  end
  assign BYPASS_TDO = byp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK cycle; returns just after the falling edge so strobes and TDO are settled.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic goto_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_ir();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Shift n bits LSB first; the last bit leaves with TMS=1 into EXIT1.
  task automatic shift(input int n, input logic [31:0] data);
    for (int i = 0; i < n; i++) begin
      logic e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("tdo[%0d]", i), {31'b0, TDO}, {31'b0, e});
      check("tdo_en_shift", {31'b0, TDO_EN}, 32'd1);
      step(i == n - 1, data[i]);
    end
  endtask

  task automatic finish_shift_dr();
    step(1'b1, 1'b0);
    check("update_dr", {31'b0, UPDATE_DR}, 32'd1);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [4:0] val);
    for (int i = 0; i < 5; i++) exp_q.push_back(i == 0);
    goto_shift_ir();
    check("shift_ir", {31'b0, SHIFT_IR}, 32'd1);
    shift(5, {27'b0, val});
    check("tdo_en_exit", {31'b0, TDO_EN}, 32'd0);
    step(1'b1, 1'b0);
    check("update_ir", {31'b0, UPDATE_IR}, 32'd1);
    step(1'b0, 1'b0);
    check("instruction", {27'b0, INSTRUCTION}, {27'b0, val});
  endtask

  initial begin
    RESET = 1'b1; TMS = 1'b1; TDI = 1'b0; USER_TDO = 1'b0;
    #1;
    check("rst_tlr", {31'b0, TEST_LOGIC_RESET}, 32'd1);
    check("rst_instr", {27'b0, INSTRUCTION}, 32'h01);
    check("rst_tdo", {30'b0, TDO, TDO_EN}, 32'd0);
    repeat (2) @(negedge TCK);
    #1;
    RESET = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr", {31'b0, TEST_LOGIC_RESET}, 32'd1);
    check("tlr_instr", {27'b0, INSTRUCTION}, 32'h01);
    check("tlr_sel_idcode", {31'b0, SEL_IDCODE}, 32'd1);
    check("tlr_tdo_en", {31'b0, TDO_EN}, 32'd0);

    step(1'b0, 1'b0);
    check("rti", {31'b0, RUN_TEST_IDLE}, 32'd1);

    // IDCODE readout, LSB first.
    for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
    goto_shift_dr();
    check("shift_dr", {31'b0, SHIFT_DR}, 32'd1);
    shift(32, 32'h0);
    check("tdo_en_ex1", {31'b0, TDO_EN}, 32'd0);
    finish_shift_dr();

    // Bypass: captured 0 first, then TDI delayed one bit.
    load_ir(5'h1F);
    check("sel_bypass", {29'b0, SEL_BYPASS, SEL_IDCODE, SEL_USER}, 32'b100);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    goto_shift_dr();
    shift(4, 32'b1101);
    finish_shift_dr();

    // USER instruction routes USER_TDO.
    load_ir(5'h02);
    check("sel_user", {29'b0, SEL_BYPASS, SEL_IDCODE, SEL_USER}, 32'b001);
    USER_TDO = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
    goto_shift_dr();
    shift(3, 32'h0);
    finish_shift_dr();
    USER_TDO = 1'b0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    goto_shift_dr();
    shift(2, 32'h0);
    finish_shift_dr();

    // Undefined opcode selects bypass; reset mid-shift abandons the scan.
    load_ir(5'h0A);
    check("sel_undef", {29'b0, SEL_BYPASS, SEL_IDCODE, SEL_USER}, 32'b100);
    goto_shift_dr();
    step(1'b0, 1'b1);
    check("mid_shift", {31'b0, SHIFT_DR}, 32'd1);
    RESET = 1'b1;
    #1;
    check("async_tlr", {31'b0, TEST_LOGIC_RESET}, 32'd1);
    check("async_instr", {27'b0, INSTRUCTION}, 32'h01);
    check("async_tdo_en", {31'b0, TDO_EN}, 32'd0);
    @(posedge TCK);
    #1;
    check("rst_no_update", {31'b0, UPDATE_DR}, 32'd0);
    @(negedge TCK);
    #1;
    RESET = 1'b0;
    step(1'b1, 1'b0);
    check("post_rst_tlr", {31'b0, TEST_LOGIC_RESET}, 32'd1);
    step(1'b0, 1'b0);
    check("post_rst_rti", {31'b0, RUN_TEST_IDLE}, 32'd1);

    // IDCODE shift interrupted by a PAUSE_DR/EXIT2_DR loop.
    for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
    goto_shift_dr();
    shift(10, 32'h0);
    step(1'b0, 1'b0);
    check("pause_tdo_en", {31'b0, TDO_EN}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("resume_shift", {31'b0, SHIFT_DR}, 32'd1);
    shift(22, 32'h0);
    finish_shift_dr();

    // Five TMS=1 edges from PAUSE_DR reach TLR; TLR then forces IDCODE.
    load_ir(5'h02);
    goto_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_tlr", {31'b0, TEST_LOGIC_RESET}, 32'd1);
    step(1'b1, 1'b0);
    check("tlr_force_instr", {27'b0, INSTRUCTION}, 32'h01);
    check("tlr_force_sel", {31'b0, SEL_IDCODE}, 32'd1);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
